// File: rtl/motor_status_pkg.sv
// Shared state encoding and logical (active-high) seven-segment patterns
// for the motor status display; bit0 = segment a ... bit6 = segment g.
package motor_status_pkg;

    typedef enum logic [1:0] {
        PARADO   = 2'b00,
        SUBINDO  = 2'b01,
        DESCENDO = 2'b10,
        ERRO     = 2'b11
    } motor_state_e;

    localparam logic [6:0] SEG_P     = 7'b1110011;
    localparam logic [6:0] SEG_A     = 7'b0000001;
    localparam logic [6:0] SEG_G     = 7'b1000000;
    localparam logic [6:0] SEG_D     = 7'b0001000;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [6:0] seg_drive(input logic [6:0] pattern, input logic active_low);
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/motor_status_channel.sv
// One motor channel: input stability filter, display FSM with direction
// animation, sticky fault bit and registered segment output.
// MOTOR_STATUS_ERR_BLINK_EN selects a blinking (vs steady) error digit.
module motor_status_channel
    import motor_status_pkg::*;
#(
    parameter int STABLE_CYC = 1000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sw,
    input  logic       tick,
    input  logic       blink_phase,
    input  logic       fault_clr,
    output logic [6:0] hex,
    output logic       fault
);

    localparam int CNT_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);

    logic [1:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    motor_state_e     state_q, state_d;
    logic [1:0]       frame_q, frame_d;
    logic             fault_q, fault_d;
    logic [6:0]       hex_q, hex_d;
    logic [6:0]       pattern;
    logic             fault_set;

`ifndef MOTOR_STATUS_ERR_BLINK_EN
    logic unused_blink_phase;
    assign unused_blink_phase = blink_phase;
`endif

    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        state_d   = state_q;
        frame_d   = frame_q;
        fault_d   = fault_q;
        pattern   = SEG_P;
        fault_set = 1'b0;

        if (sw != cand_q) begin
            cand_d = sw;
            cnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
            state_d = motor_state_e'(cand_q);
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (state_d != state_q) begin
            frame_d = 2'd0;
        end else if (tick && (state_q == SUBINDO || state_q == DESCENDO)) begin
            frame_d = (frame_q == 2'd2) ? 2'd0 : frame_q + 2'd1;
        end

        // Direct reversal without passing through PARADO is treated as a fault.
        fault_set = (state_d == ERRO && state_q != ERRO) ||
                    (state_q == SUBINDO && state_d == DESCENDO) ||
                    (state_q == DESCENDO && state_d == SUBINDO);
        if (fault_clr && state_q != ERRO) fault_d = 1'b0;
        if (fault_set) fault_d = 1'b1;

        case (state_q)
            PARADO:   pattern = SEG_P;
            SUBINDO:  pattern = (frame_q == 2'd0) ? SEG_D : (frame_q == 2'd1) ? SEG_G : SEG_A;
            DESCENDO: pattern = (frame_q == 2'd0) ? SEG_A : (frame_q == 2'd1) ? SEG_G : SEG_D;
            ERRO: begin
`ifdef MOTOR_STATUS_ERR_BLINK_EN
                pattern = blink_phase ? SEG_BLANK : SEG_E;
`else
                pattern = SEG_E;
`endif
            end
            default:  pattern = SEG_P;
        endcase
        hex_d = seg_drive(pattern, ACTIVE_LOW);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q  <= 2'b00;
            cnt_q   <= '0;
            state_q <= PARADO;
            frame_q <= 2'd0;
            fault_q <= 1'b0;
            hex_q   <= seg_drive(SEG_P, ACTIVE_LOW);
        end else begin
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            frame_q <= frame_d;
            fault_q <= fault_d;
            hex_q   <= hex_d;
        end
    end

    assign hex   = hex_q;
    assign fault = fault_q;

endmodule

// File: rtl/motor_status_display.sv
// N_MOTORS-digit motor status display with a shared animation tick/blink
// generator. Define MOTOR_STATUS_ERR_BLINK_EN to blink error digits.
module motor_status_display
    import motor_status_pkg::*;
#(
    parameter int N_MOTORS   = 2,
    parameter int CLK_HZ     = 50000000,
    parameter int ANIM_HZ    = 4,
    parameter int STABLE_CYC = 1000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [2*N_MOTORS-1:0] SW,
    input  logic                  fault_clr,
    output logic [7*N_MOTORS-1:0] HEX,
    output logic [N_MOTORS-1:0]   fault
);

    localparam int DIV   = CLK_HZ / ANIM_HZ;
    localparam int DIV_W = $clog2(DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    logic             blink;

    always_comb begin
        tick  = (div_q == DIV_MAX);
        div_d = tick ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) div_q <= '0;
        else       div_q <= div_d;
    end

`ifdef MOTOR_STATUS_ERR_BLINK_EN
    logic blink_q, blink_d;

    always_comb blink_d = tick ? ~blink_q : blink_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) blink_q <= 1'b0;
        else       blink_q <= blink_d;
    end

    assign blink = blink_q;
`else
    assign blink = 1'b0;
`endif

    for (genvar i = 0; i < N_MOTORS; i++) begin : g_ch
        motor_status_channel #(
            .STABLE_CYC (STABLE_CYC),
            .ACTIVE_LOW (ACTIVE_LOW != 0)
        ) u_ch (
            .clk         (CLOCK_50),
            .reset       (reset),
            .sw          (SW[2*i+1:2*i]),
            .tick        (tick),
            .blink_phase (blink),
            .fault_clr   (fault_clr),
            .hex         (HEX[7*i+6:7*i]),
            .fault       (fault[i])
        );
    end

endmodule

// File: tb/tb_motor_status_display.sv
// Directed bench for motor_status_display: DIV=10, STABLE_CYC=3, two channels,
// active-low segments. Edge numbers count rising edges after reset release.
module tb_motor_status_display;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  sw;
    logic        fault_clr;
    logic [13:0] hex;
    logic [1:0]  fault;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    localparam logic [6:0] H_P     = 7'b0001100;
    localparam logic [6:0] H_D     = 7'b1110111;
    localparam logic [6:0] H_G     = 7'b0111111;
    localparam logic [6:0] H_A     = 7'b1111110;
    localparam logic [6:0] H_E     = 7'b0000110;
`ifdef MOTOR_STATUS_ERR_BLINK_EN
    localparam logic [6:0] H_ERR_1 = 7'b1111111;
`else
    localparam logic [6:0] H_ERR_1 = 7'b0000110;
`endif

    motor_status_display #(
        .N_MOTORS   (2),
        .CLK_HZ     (40),
        .ANIM_HZ    (4),
        .STABLE_CYC (3),
        .ACTIVE_LOW (1)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .SW        (sw),
        .fault_clr (fault_clr),
        .HEX       (hex),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task go(input int k);
        repeat (k - cyc) @(posedge clk);
        cyc = k;
        #1;
    endtask

    task restart(input logic [3:0] sw_val);
        reset     = 1'b1;
        sw        = sw_val;
        fault_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        reset = 1'b1; sw = 4'b0000; fault_clr = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_hex", hex, {H_P, H_P});
        check("reset_fault", {12'd0, fault}, 14'd0);

        // Glitch of 2 cycles on ch0 is ignored
        restart(4'b0001);
        go(2);
        sw = 4'b0000;
        check("glitch_hex_e2", hex, {H_P, H_P});
        go(8);
        check("glitch_hex_e8", hex, {H_P, H_P});
        check("glitch_fault", {12'd0, fault}, 14'd0);

        // ch0 SUBINDO animation
        restart(4'b0001);
        go(4);
        check("sub_e4_still_p", hex, {H_P, H_P});
        go(5);
        check("sub_frame0_d", hex, {H_P, H_D});
        go(10);
        check("sub_e10_hold_d", hex, {H_P, H_D});
        go(11);
        check("sub_frame1_g", hex, {H_P, H_G});
        go(21);
        check("sub_frame2_a", hex, {H_P, H_A});
        go(31);
        check("sub_wrap_d", hex, {H_P, H_D});
        check("sub_no_fault", {12'd0, fault}, 14'd0);

        // Reset mid-animation
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_hex", hex, {H_P, H_P});
        check("midreset_fault", {12'd0, fault}, 14'd0);

        // ch1 ERRO: fault, blink, clear behaviour
        restart(4'b1100);
        go(3);
        check("err_fault_pre", {12'd0, fault}, 14'd0);
        go(4);
        check("err_fault_set", {12'd0, fault}, 14'd2);
        go(5);
        check("err_hex_e", hex, {H_E, H_P});
        go(10);
        check("err_e10_hold", hex, {H_E, H_P});
        go(11);
        check("err_phase1", hex, {H_ERR_1, H_P});
        go(21);
        check("err_phase0_again", hex, {H_E, H_P});
        fault_clr = 1'b1;
        go(22);
        fault_clr = 1'b0;
        check("err_clr_ignored", {12'd0, fault}, 14'd2);
        sw = 4'b0000;
        go(26);
        check("err_left_fault_kept", {12'd0, fault}, 14'd2);
        fault_clr = 1'b1;
        go(27);
        fault_clr = 1'b0;
        check("err_clr_fault", {12'd0, fault}, 14'd0);
        check("err_back_p", hex, {H_P, H_P});

        // ch0 direct reversal SUBINDO -> DESCENDO
        restart(4'b0001);
        go(5);
        sw = 4'b0010;
        go(8);
        check("rev_fault_pre", {12'd0, fault}, 14'd0);
        go(9);
        check("rev_fault_set", {12'd0, fault}, 14'd1);
        go(10);
        check("rev_hex_a", hex, {H_P, H_A});
        fault_clr = 1'b1;
        go(11);
        fault_clr = 1'b0;
        check("rev_clr", {12'd0, fault}, 14'd0);
        check("rev_frame1_g", hex, {H_P, H_G});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/motor_status_display.md
Name: motor_status_display

Overview:
- Parametrised successor to the single-motor combinational status decoder.
- Drives N_MOTORS seven-segment digits, each showing the 2-bit motor status (00 parado, 01 subindo, 10 descendo, 11 erro).
- Filters glitchy status inputs, animates direction while moving, and blinks on error.
- Latches a sticky fault on error or direct reversal. Sits between the motor controllers and the board HEX displays.

Parameters:
- N_MOTORS, 2, number of channels/digits
- CLK_HZ, 50000000, clock frequency
- ANIM_HZ, 4, animation tick rate; DIV = CLK_HZ/ANIM_HZ, must be ≥2
- STABLE_CYC, 1000, consecutive identical cycles before a status is accepted (≥1)
- ACTIVE_LOW, 1, 1 = segment outputs inverted (board displays)

Ports:
- CLOCK_50  in  1  clock
- reset  in  1  synchronous, active-high
- SW  in  2*N_MOTORS  raw status; channel i = SW[2i+1:2i]
- fault_clr  in  1  clears all sticky fault bits
- HEX  out  7*N_MOTORS  segments; digit i = HEX[7i+6:7i], bit0=a … bit6=g
- fault  out  N_MOTORS  sticky per-channel fault

Behaviour:
Clocking and reset:
- Single clock CLOCK_50; reset synchronous, active-high, and it overrides everything.
- Reset values: filtered state 00, candidate 00, stable counter 0, frame 0, div counter 0, blink phase 0, fault 0.
- HEX per digit at reset is the parado pattern: logical 7'b1110011, i.e. 7'b0001100 when ACTIVE_LOW.
- Reset mid-animation returns to these values on the next edge.

Tick generator:
- Free-running counter 0..DIV-1.
- tick=1 for one cycle when the counter equals DIV-1, then it wraps to 0.
- blink phase toggles on each tick.

Stability filter (per channel):
- If SW_i differs from candidate: candidate←SW_i, counter←0.
- Otherwise, if counter < STABLE_CYC-1, counter increments.
- When counter == STABLE_CYC-1 and SW_i == candidate, filtered state ← candidate.
- Acceptance latency: a change held constant is accepted STABLE_CYC cycles after first sampled.
- A glitch shorter than STABLE_CYC cycles never changes the filtered state.

Display FSM (per channel; states PARADO, SUBINDO, DESCENDO, ERRO = filtered state):
- On any state change, frame←0.
- In SUBINDO/DESCENDO, frame advances 0→1→2→0 on each tick. Frame holds otherwise.
- Logical patterns:
  - PARADO: 7'b1110011 ("P").
  - SUBINDO frames 0/1/2: d 7'b0001000, g 7'b1000000, a 7'b0000001 (upward sweep).
  - DESCENDO frames 0/1/2: a, g, d.
  - ERRO: "E" 7'b1111001 when blink phase=0, blank 7'b0000000 when phase=1.
- HEX is registered: it reflects state/frame/phase one cycle after they update.
- Output = ACTIVE_LOW ? ~pattern : pattern.

Fault (per channel, sticky):
- Set on the cycle the filtered state enters ERRO.
- Also set on an accepted direct transition 01→10 or 10→01 (no intervening 00).
- Cleared by fault_clr. If set and clear occur in the same cycle, set wins.
- Remains 1 while the state stays ERRO even with fault_clr asserted.

Optional Feature:
- MOTOR_STATUS_ERR_BLINK_EN defined: ERRO blinks as above.
- Undefined: ERRO shows a steady "E" and blink phase logic is removed. All other behaviour is unchanged.

Decomposition:
- Package motor_status_pkg holds:
  - state enum (PARADO=2'b00, SUBINDO=2'b01, DESCENDO=2'b10, ERRO=2'b11)
  - logical segment constants SEG_P, SEG_A, SEG_G, SEG_D, SEG_E, SEG_BLANK
- Sub-module motor_status_channel: one filter + FSM + fault + HEX register, instantiated N_MOTORS times by generate.
- Tick generator stays in the top level and is shared by all channels.

Test Plan (CLK_HZ=40, ANIM_HZ=4 so DIV=10, STABLE_CYC=3, N_MOTORS=2, ACTIVE_LOW=1, feature defined):
- Reset held 2 cycles → HEX=14'b0001100_0001100, fault=2'b00.
- SW ch0=01 for 2 cycles then back to 00 → ch0 HEX stays 0001100, fault stays 0.
- SW ch0=01 held:
  - state accepted after 3 cycles; HEX shows 1110111 (d) next cycle.
  - then 0111111 (g) and 1111110 (a) on successive ticks, 10 cycles apart.
  - then wraps back to d.
- ch1 SW=11 held → fault[1]=1 after acceptance; HEX1 alternates 0000110 and 1111111 every 10 cycles.
- ch1 back to 11→00, then fault_clr pulsed 1 cycle → fault[1]=0 next cycle. Pulsing fault_clr while still ERRO → fault[1] stays 1.
- ch0 01 held, then 10 held (no 00) → fault[0]=1 on acceptance of 10; HEX0 shows 1111110 (DESCENDO frame 0).
